// File: rtl/sentinel_key_presenter_if.sv
// Handshake bundle between the Sentinel key presenter, its local controller and the lock.
interface sentinel_key_presenter_if;
    logic       start;
    logic       abort;
    logic [7:0] glow_in;
    logic [7:0] key_out;
    logic       key_valid;
    logic       busy;
    logic       granted;
    logic       denied;
    logic [3:0] attempts;

    // master: the presenter itself; slave: controller + lock side
    modport master (
        input  start, abort, glow_in,
        output key_out, key_valid, busy, granted, denied, attempts
    );
    modport slave (
        output start, abort, glow_in,
        input  key_out, key_valid, busy, granted, denied, attempts
    );
endinterface

// File: rtl/sentinel_key_presenter.sv
// Initiator side of the Sentinel gate: presents the key, waits for a confirmed glow,
// retries after a blanking gap, and reports granted/denied.
module sentinel_key_presenter #(
    parameter logic [7:0]  KEY            = 8'hB6,
    parameter logic [7:0]  IDLE_KEY       = 8'h00,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    sentinel_key_presenter_if.master  bus
);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ATT_W   = 4;
    localparam logic [7:0]  GLOW_OK = 8'hFF;

    typedef enum logic [2:0] {
        IDLE, PRESENT, WAIT, GAP, GRANTED, DENIED
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        conf, conf_nxt;
    logic [ATT_W-1:0]  attempts_q, attempts_nxt;
    logic [7:0]        key_q, key_nxt;
    logic              key_valid_q, key_valid_nxt;
    logic              busy_q, busy_nxt;
    logic              granted_q, granted_nxt;
    logic              denied_q, denied_nxt;

    // State, counters and outputs all register together so outputs track the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            conf        <= '0;
            attempts_q  <= '0;
            key_q       <= IDLE_KEY;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            granted_q   <= 1'b0;
            denied_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            conf        <= conf_nxt;
            attempts_q  <= attempts_nxt;
            key_q       <= key_nxt;
            key_valid_q <= key_valid_nxt;
            busy_q      <= busy_nxt;
            granted_q   <= granted_nxt;
            denied_q    <= denied_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        conf_nxt     = '0;
        attempts_nxt = attempts_q;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.start) begin
                    state_nxt    = PRESENT;
                    attempts_nxt = ATT_W'(1);
                end
            end
            PRESENT: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (bus.glow_in == GLOW_OK) conf_nxt = conf + 2'd1;
                // A confirmed grant beats a timeout landing on the same cycle
                if (conf_nxt == 2'd2) begin
                    state_nxt = GRANTED;
                    cnt_nxt   = '0;
                    conf_nxt  = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    conf_nxt  = '0;
                    state_nxt = (attempts_q <= ATT_W'(MAX_RETRIES)) ? GAP : DENIED;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt    = PRESENT;
                    cnt_nxt      = '0;
                    attempts_nxt = attempts_q + ATT_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GRANTED: begin
                if (!bus.start) state_nxt = IDLE;
            end
            DENIED: begin
                if (!bus.start) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (bus.abort) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            conf_nxt     = '0;
            attempts_nxt = attempts_q;
        end

        key_valid_nxt = (state_nxt == PRESENT) || (state_nxt == WAIT) || (state_nxt == GRANTED);
        key_nxt       = key_valid_nxt ? KEY : IDLE_KEY;
        busy_nxt      = (state_nxt == PRESENT) || (state_nxt == WAIT) || (state_nxt == GAP);
        granted_nxt   = (state_nxt == GRANTED);
        denied_nxt    = (state_nxt == DENIED);
    end

    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.granted   = granted_q;
    assign bus.denied    = denied_q;
    assign bus.attempts  = attempts_q;

endmodule

// File: tb/tb_sentinel_key_presenter.sv
// Directed bench for sentinel_key_presenter: table-driven grant flow plus retry/abort/reset sequences.
module tb_sentinel_key_presenter;
    logic clk = 1'b0;
    logic rst;
    logic lock_auto;
    logic [7:0] glow_manual;

    sentinel_key_presenter_if bus ();

    sentinel_key_presenter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Lock model: lights every glow segment while the right key is on the bus
    assign bus.glow_in = lock_auto ? ((bus.key_out == 8'hB6) ? 8'hFF : 8'h00) : glow_manual;

    typedef struct packed {
        logic [7:0] key;
        logic       kv;
        logic       busy;
        logic       gr;
        logic       dn;
        logic [3:0] att;
    } exp_t;

    typedef struct packed {
        logic start;
        exp_t exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".key_out"},   bus.key_out,          e.key);
        chk({tag, ".key_valid"}, 8'(bus.key_valid),    8'(e.kv));
        chk({tag, ".busy"},      8'(bus.busy),         8'(e.busy));
        chk({tag, ".granted"},   8'(bus.granted),      8'(e.gr));
        chk({tag, ".denied"},    8'(bus.denied),       8'(e.dn));
        chk({tag, ".attempts"},  8'(bus.attempts),     8'(e.att));
    endtask

    function automatic exp_t mk(input logic [7:0] key, input logic kv, input logic busy,
                                input logic gr, input logic dn, input logic [3:0] att);
        exp_t e;
        e.key = key; e.kv = kv; e.busy = busy; e.gr = gr; e.dn = dn; e.att = att;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [11];
        logic [7:0] glitch [9];
        exp_t       e;
        exp_t       present_e, grant_e, idle_e;
        logic       gap, den;
        logic [3:0] att;

        present_e = mk(8'hB6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        grant_e   = mk(8'hB6, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
        idle_e    = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

        // Grant flow: row c holds start during cycle c and outputs expected at cycle c+1
        for (int i = 0; i < 7; i++) begin
            vecs[i].start = 1'b1;
            vecs[i].exp   = (i == 6) ? grant_e : present_e;
        end
        for (int i = 7; i < 10; i++) begin
            vecs[i].start = 1'b1;
            vecs[i].exp   = grant_e;
        end
        vecs[10].start = 1'b0;
        vecs[10].exp   = idle_e;

        rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
        lock_auto = 1'b1; glow_manual = 8'h00;
        tick(); tick();
        chk_all("reset", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        rst = 1'b0;
        tick();
        chk_all("idle", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

        // Grant flow, lock model active
        for (int i = 0; i < 11; i++) begin
            bus.start = vecs[i].start;
            tick();
            chk_all($sformatf("grant_c%0d", i + 1), vecs[i].exp);
        end

        // Lock never grants: two gaps then denied
        lock_auto = 1'b0; glow_manual = 8'h00;
        bus.start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            gap = (c >= 21 && c <= 24) || (c >= 45 && c <= 48);
            den = (c >= 69);
            att = (c < 25) ? 4'd1 : (c < 49) ? 4'd2 : 4'd3;
            e   = mk((!gap && !den) ? 8'hB6 : 8'h00, !gap && !den, !den, 1'b0, den, att);
            chk_all($sformatf("deny_c%0d", c), e);
        end
        bus.start = 1'b0;
        tick();
        chk_all("deny_idle", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));

        // Glow glitch: FF in PRESENT ignored, lone FF in WAIT not enough
        glitch[0] = 8'h00; glitch[1] = 8'hFF; glitch[2] = 8'hFF; glitch[3] = 8'hFF;
        glitch[4] = 8'hFF; glitch[5] = 8'hFF; glitch[6] = 8'h00; glitch[7] = 8'hFF;
        glitch[8] = 8'hFF;
        bus.start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            glow_manual = glitch[c];
            tick();
            chk_all($sformatf("glitch_c%0d", c + 1), (c == 8) ? grant_e : present_e);
        end
        bus.start = 1'b0; glow_manual = 8'h00;
        tick();
        chk_all("glitch_idle", idle_e);

        // Grant confirmed on timer values 14 and 15 beats the timeout
        bus.start = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            glow_manual = (c == 19 || c == 20) ? 8'hFF : 8'h00;
            tick();
            chk_all($sformatf("late_c%0d", c + 1), (c == 20) ? grant_e : present_e);
        end
        bus.start = 1'b0; glow_manual = 8'h00;
        tick();
        chk_all("late_idle", idle_e);

        // Abort in WAIT of attempt 2
        bus.start = 1'b1;
        for (int c = 0; c < 30; c++) tick();
        chk_all("abort_pre", mk(8'hB6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2));
        bus.abort = 1'b1; bus.start = 1'b0;
        tick();
        chk_all("abort_idle", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
        bus.abort = 1'b0;
        tick();
        chk_all("abort_hold", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
        bus.start = 1'b1;
        tick();
        chk_all("abort_restart", present_e);
        bus.abort = 1'b1; bus.start = 1'b0;
        tick();
        bus.abort = 1'b0;
        tick();
        chk_all("abort_idle2", idle_e);

        // Reset while GRANTED with start still high
        lock_auto = 1'b1;
        bus.start = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        chk_all("rst_pre", grant_e);
        rst = 1'b1;
        tick();
        chk_all("rst_1", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        tick();
        chk_all("rst_2", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        rst = 1'b0;
        tick();
        chk_all("rst_release", present_e);
        bus.start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
